alu_seq_ctrl: RTL

//  Program sequencer for the 4-register ALU datapath (9-bit control word c, 8-bit data_in/data_out).

---
 rtl/alu_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Microprogram sequencer for the 4-register ALU datapath: host-loaded control words issued one per clock,
// stalling with NOP while a data_in-reading word lacks valid input. Define SEQ_LOOP_EN for multi-pass runs.
module alu_seq_ctrl #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter logic [8:0] NOP   = 9'h1f8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          din_valid,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  output logic          din_take,
  output logic [8:0]    c_out,
  output logic          dout_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [8:0]    r_c_out;
  logic          r_din_take;
  logic          r_dout_valid;
  logic          r_done;
`ifdef SEQ_LOOP_EN
  logic [7:0]    r_loop;
`endif

  logic [8:0]    w_word;
  logic          w_rd;
  logic          w_last;
  logic [AW:0]   w_len_clip;

  // srcB only matters for non-pass-through ops (op 0 forwards srcA)
  function automatic logic is_rd(input logic [8:0] word);
    is_rd = ((word[4:3] == 2'd3) || ((word[2:0] != 3'd0) && (word[6:5] == 2'd3)))
            && (word != NOP);
  endfunction

  function automatic logic is_wr(input logic [8:0] word);
    is_wr = (word[8:7] == 2'd3) && (word != NOP);
  endfunction

  assign w_word     = r_mem[r_pc];
  assign w_rd       = is_rd(w_word);
  assign w_last     = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_len_clip = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  always_ff @(posedge clk) begin
    if (prog_we && (r_state == S_IDLE)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_len        <= '0;
      r_c_out      <= NOP;
      r_din_take   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
`ifdef SEQ_LOOP_EN
      r_loop       <= '0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_dout_valid <= is_wr(r_c_out);
      case (r_state)
        S_IDLE: begin
          r_c_out    <= NOP;
          r_din_take <= 1'b0;
          if (start) begin
            if (w_len_clip != '0) begin
              r_state <= S_RUN;
              r_pc    <= '0;
              r_len   <= w_len_clip;
`ifdef SEQ_LOOP_EN
              r_loop  <= loop_cnt;
`endif
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN, S_WAIT: begin
          if (w_rd && !din_valid) begin
            r_c_out    <= NOP;
            r_din_take <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_c_out    <= w_word;
            r_din_take <= w_rd;
            if (w_last) begin
`ifdef SEQ_LOOP_EN
              r_pc <= '0;
              if (r_loop != 8'd0) begin
                r_loop  <= r_loop - 8'd1;
                r_state <= S_RUN;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
`else
              r_pc    <= '0;
              r_state <= S_IDLE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_c_out <= NOP;
        end
      endcase
    end
  end

  assign c_out      = r_c_out;
  assign din_take   = r_din_take;
  assign dout_valid = r_dout_valid;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule
